// File: rtl/stopwatch_ctrl.sv
// Stopwatch control unit: start/stop button debounce, RUN/PAUSE/HOLD/IDLE sequencing,
// 10 ms count tick, counter clear and display-freeze strobes for the BCD datapath.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned DB_CYCLES = 20000
) (
  input  logic       ADC_CLK_10,
  input  logic       KEY0,
  input  logic       btn_n,
  input  logic       lap_sw,
  output logic       count_en,
  output logic       count_clr,
  output logic       disp_hold,
  output logic [1:0] state
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DbLast   = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StHold  = 2'd3
  } state_e;

  logic [1:0]    sync_q;
  logic          db_q;
  logic          db_last_q;
  logic [DW-1:0] db_cnt_q;
  logic          press_q;
  logic [PW-1:0] presc_q;
  state_e        state_q;
  state_e        state_d;
  logic          running;

  // Button path: 2-flop synchronizer, stability counter, falling-edge press pulse.
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      sync_q    <= 2'b11;
      db_q      <= 1'b1;
      db_last_q <= 1'b1;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_n};
      db_last_q <= db_q;
      press_q   <= db_last_q & ~db_q;
      if (sync_q[1] == db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbLast) begin
        db_q     <= sync_q[1];
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign running = (state_q == StRun) || (state_q == StHold);

  always_comb begin
    state_d = state_q;
    if (press_q) begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = lap_sw ? StHold : StPause;
        StHold:  state_d = StRun;
        StPause: state_d = lap_sw ? StIdle : StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Tick is decided on the pre-transition state so a press never swallows a pending tick.
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      count_en  <= 1'b0;
      count_clr <= 1'b1;
      disp_hold <= 1'b0;
    end else begin
      state_q   <= state_d;
      disp_hold <= (state_d == StHold);
      count_en  <= running && (presc_q == TickLast);
      count_clr <= (state_q == StPause) && (state_d == StIdle);
      if ((state_q == StIdle) || (state_d == StIdle)) begin
        presc_q <= '0;
      end else if (running) begin
        presc_q <= (presc_q == TickLast) ? '0 : presc_q + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: expected output vectors are queued per cycle as stimulus is
// driven, then popped and compared on the falling clock edge.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic       clk = 1'b0;
  logic       key0;
  logic       btn_n;
  logic       lap_sw;
  logic       count_en;
  logic       count_clr;
  logic       disp_hold;
  logic [1:0] state;
  logic [4:0] obs;

  stopwatch_ctrl #(
    .TICK_DIV (TD),
    .DB_CYCLES(DB)
  ) dut (
    .ADC_CLK_10(clk),
    .KEY0      (key0),
    .btn_n     (btn_n),
    .lap_sw    (lap_sw),
    .count_en  (count_en),
    .count_clr (count_clr),
    .disp_hold (disp_hold),
    .state     (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {count_en, count_clr, disp_hold, state};

  typedef struct {
    int         at;
    string      tag;
    logic [4:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [1:0] exp_st;
  int         base;
  int         frozen;

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s @cyc %0d: got {en,clr,hold,st}=%b want %b", tag, cyc, got, want);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check_eq(sb[i].tag, obs, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  function automatic int md(input int x);
    return ((x % TD) + TD) % TD;
  endfunction

  function automatic logic runs(input logic [1:0] s);
    return (s == S_RUN) || (s == S_HOLD);
  endfunction

  task automatic push(input int at, input string tag, input logic en, input logic clr,
                      input logic [1:0] st);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.exp = {en, clr, (st == S_HOLD), st};
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      push(cyc + k, tag, runs(exp_st) && (md(cyc + k - 1 - base) == TD - 1), 1'b0, exp_st);
    end
    repeat (n) tick();
  endtask

  // Press lasting DB+3 cycles then a release of DB+3 cycles; state moves at edge c+DB+4.
  task automatic do_press(input logic lap, input logic [1:0] nxt, input string tag);
    int         c;
    int         e;
    int         nb;
    logic [1:0] cur;
    logic       en;
    c   = cyc;
    e   = c + DB + 4;
    nb  = base;
    cur = exp_st;
    if (cur == S_IDLE && nxt == S_RUN) nb = e;
    else if (cur == S_PAUSE && nxt == S_RUN) nb = e - frozen;
    else if (runs(cur) && nxt == S_PAUSE) frozen = md(e - base);
    for (int k = c + 1; k <= c + 2 * DB + 6; k++) begin
      if (k <= e) en = runs(cur) && (md(k - 1 - base) == TD - 1);
      else        en = runs(nxt) && (md(k - 1 - nb) == TD - 1);
      push(k, tag, en, (k == e) && (cur == S_PAUSE) && (nxt == S_IDLE), (k < e) ? cur : nxt);
    end
    lap_sw = lap;
    btn_n  = 1'b0;
    repeat (DB + 3) tick();
    btn_n  = 1'b1;
    repeat (DB + 3) tick();
    exp_st = nxt;
    base   = nb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    key0   = 1'b0;
    btn_n  = 1'b1;
    lap_sw = 1'b0;
    exp_st = S_IDLE;
    base   = 0;
    frozen = 0;

    for (int k = 1; k <= 5; k++) push(k, "rst_hold", 1'b0, 1'b1, S_IDLE);
    repeat (5) tick();
    key0 = 1'b1;
    idle(3, "rst_release");

    // Short glitch must not reach the debounced level.
    for (int k = 1; k <= 10; k++) push(cyc + k, "glitch", 1'b0, 1'b0, S_IDLE);
    btn_n = 1'b0;
    repeat (2) tick();
    btn_n = 1'b1;
    repeat (8) tick();

    do_press(1'b0, S_RUN, "start");
    idle(8, "run");

    // Pause with the prescaler at 2, so resume ticks 2 cycles later.
    for (int g = 0; g < TD && md(cyc + DB + 4 - base) != 2; g++) idle(1, "run_align");
    do_press(1'b0, S_PAUSE, "pause");
    idle(6, "paused");
    do_press(1'b0, S_RUN, "resume");
    idle(4, "run2");

    do_press(1'b1, S_HOLD, "hold");
    lap_sw = 1'b0;
    idle(9, "hold_lap_toggle");
    do_press(1'b1, S_RUN, "unhold");
    idle(4, "run3");

    do_press(1'b0, S_PAUSE, "pause2");
    do_press(1'b1, S_IDLE, "clear");
    idle(4, "idle_after_clr");
    do_press(1'b0, S_RUN, "restart");

    // Press edge coincides with prescaler at TICK_DIV-1.
    for (int g = 0; g < TD && md(cyc + DB + 3 - base) != TD - 1; g++) idle(1, "tick_align");
    do_press(1'b0, S_PAUSE, "tick_on_press");
    do_press(1'b0, S_RUN, "resume2");

    // Assert reset while count_en is high.
    for (int g = 0; g < TD && md(cyc - 1 - base) != TD - 1; g++) idle(1, "pre_rst");
    key0 = 1'b0;
    #1;
    check_eq("async_rst", obs, 5'b01000);
    exp_st = S_IDLE;
    for (int k = 1; k <= 2; k++) push(cyc + k, "rst_mid", 1'b0, 1'b1, S_IDLE);
    repeat (2) tick();
    key0 = 1'b1;
    idle(3, "rst_release2");

    check_eq("sb_drained", 5'(sb.size()), 5'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control unit for the Project 2 stopwatch datapath on the DE10-Lite.
- Debounces the KEY[1] start/stop button and runs the RUN/PAUSE/HOLD/IDLE state machine.
- Generates the 10 ms count-enable tick, the clear pulse and the display-freeze strobe that sequence the BCD counter/HEX display datapath.
- Sits between the board pins (KEY, SW[9]) and the counter datapath inside proj2.

Parameters:
- TICK_DIV, 100000: ADC_CLK_10 cycles per count tick (10 ms at 10 MHz); must be >= 2.
- DB_CYCLES, 20000: consecutive stable cycles required to accept a button level change (2 ms); must be >= 1.

Ports:
- ADC_CLK_10  input  1  sole clock, 10 MHz board clock.
- KEY0  input  1  asynchronous, active-low reset (board KEY[0]).
- btn_n  input  1  raw start/stop button, active-low (board KEY[1]); asynchronous to the clock.
- lap_sw  input  1  mode switch (board SW[9]): 1 = lap/clear mode, 0 = plain pause mode.
- count_en  output  1  one-cycle tick to the counter datapath.
- count_clr  output  1  clear request to the counter datapath.
- disp_hold  output  1  1 = freeze the displayed value.
- state  output  2  current state for LEDR: IDLE=0, RUN=1, PAUSE=2, HOLD=3.

Behaviour:
- Reset: one clock ADC_CLK_10; reset KEY0 is asynchronous, active-low. While KEY0=0 all registers clear immediately:
  - state=IDLE, count_en=0, disp_hold=0, prescaler=0, debounce counter=0.
  - Synchronizer flops and debounced level are set to 1 (released).
  - count_clr=1, held high through reset and deasserted on the first rising edge after KEY0 goes high.
  - Reset mid-operation aborts any count or debounce in progress; there is no partial state retention.
- Synchronizer: btn_n passes through a 2-flop synchronizer before use.
- Debounce:
  - Counter increments on each cycle where the synchronized level differs from the debounced level.
  - It clears on any cycle where they match.
  - On the edge where the counter equals DB_CYCLES-1 and the mismatch persists, the debounced level flips and the counter clears.
  - Glitches shorter than DB_CYCLES cycles never change the debounced level.
- press: a registered one-cycle pulse on the cycle after the debounced level falls 1->0. Release generates no event.
- Latency: numbering the first edge that samples btn_n=0 as edge 1, press=1 after edge DB_CYCLES+3 and the state updates at edge DB_CYCLES+4.
- FSM transitions (evaluated only when press=1; otherwise the state holds):
  - IDLE -> RUN.
  - RUN -> PAUSE if lap_sw=0; RUN -> HOLD if lap_sw=1.
  - HOLD -> RUN.
  - PAUSE -> RUN if lap_sw=0; PAUSE -> IDLE if lap_sw=1.
- lap_sw: sampled directly at the press edge, with no synchronizer (it is a static switch).
- Prescaler:
  - Counts 0..TICK_DIV-1 while state is RUN or HOLD, then wraps to 0.
  - Frozen in PAUSE, so sub-tick time is preserved.
  - Forced to 0 on the IDLE->RUN transition and while in IDLE.
- count_en:
  - Registered. It is 1 for exactly one cycle after any edge where the prescaler equals TICK_DIV-1 and state is RUN or HOLD.
  - Decided on the pre-transition state: a tick coinciding with a press edge is still issued.
  - Never asserted in IDLE or PAUSE.
- count_clr: registered one-cycle pulse on the edge that enters IDLE from PAUSE, plus the reset behaviour above.
- disp_hold: 1 exactly while state=HOLD; it is registered with the state. The counter keeps running underneath (count_en continues).
- HOLD and lap_sw: toggling lap_sw while in HOLD has no effect; the next press always returns to RUN.
- No long-press or double-press handling: every accepted falling edge is one event.

Test Plan (TICK_DIV=4, DB_CYCLES=3):
1. Reset and release:
   - Stimulus: KEY0=0 for 5 cycles, then 1.
   - Required: count_clr=1 during reset and 0 from the first edge after release; state=0, count_en=0, disp_hold=0.
2. Debounce and start:
   - Stimulus: btn_n pulses low for 2 cycles.
   - Required: no state change.
   - Stimulus: btn_n held low.
   - Required: state=1 at edge 7. count_en then pulses once every 4 cycles, first pulse 4 cycles after entering RUN.
3. Pause keeps the fraction:
   - Stimulus: press with lap_sw=0 when prescaler=2.
   - Required: state=2 and no count_en while paused.
   - Stimulus: press again.
   - Required: state=1 and the first count_en 2 cycles later.
4. Lap mode:
   - Stimulus: lap_sw=1, press in RUN.
   - Required: state=3, disp_hold=1, count_en continues every 4 cycles.
   - Stimulus: press.
   - Required: state=1, disp_hold=0.
5. Clear:
   - Stimulus: in PAUSE with lap_sw=1, press.
   - Required: state=0, count_clr high for exactly 1 cycle, prescaler=0.
6. Simultaneous events and reset mid-run:
   - Stimulus: press lands on the edge where prescaler=3 in RUN.
   - Required: count_en=1 on the next cycle and state=2.
   - Stimulus: KEY0 low mid-RUN.
   - Required: all outputs reach reset values immediately without a clock.
